// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable FIFO family.
// Read-mode encodings and counter width helper.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through reads,
// static almost-full/almost-empty thresholds, flush and sticky error flags.
module prog_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("prog_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("prog_fifo: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("prog_fifo: AE_THRESH out of range");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("prog_fifo: FWFT must be 0 or 1");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flush wins over both requests in the same cycle.
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    assign empty        = (count == '0);
    assign full         = (count == FULL_C);
    assign almost_empty = (count <= AE_C);
    assign almost_full  = (count >= AF_C);

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(din),
        .raddr(rd_ptr),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en & full)  overflow  <= 1'b1;
            if (rd_en & empty) underflow <= 1'b1;
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign dout     = empty ? '0 : ram_rdata;
        assign rd_valid = ~empty;
    end else begin : g_std
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout     <= '0;
                rd_valid <= 1'b0;
            end else if (flush) begin
                dout     <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) dout <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_prog_fifo.sv
// Scoreboard bench: STD and FWFT instances share stimulus; a queue model
// predicts occupancy, flags and read data.
module tb_prog_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;

    logic [DW-1:0] dout_s, dout_f;
    logic          rv_s, rv_f;
    logic          empty_s, full_s, ae_s, af_s, ovf_s, unf_s;
    logic          empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
    logic [CW-1:0] count_s, count_f;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_std[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    always #5 clk = ~clk;

    prog_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0),
                .AF_THRESH(14), .AE_THRESH(2)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .din(din),
        .wr_en(wr_en), .rd_en(rd_en), .dout(dout_s), .rd_valid(rv_s),
        .empty(empty_s), .full(full_s), .almost_empty(ae_s),
        .almost_full(af_s), .count(count_s), .overflow(ovf_s),
        .underflow(unf_s)
    );

    prog_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1),
                .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .din(din),
        .wr_en(wr_en), .rd_en(rd_en), .dout(dout_f), .rd_valid(rv_f),
        .empty(empty_f), .full(full_f), .almost_empty(ae_f),
        .almost_full(af_f), .count(count_f), .overflow(ovf_f),
        .underflow(unf_f)
    );

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // STD read monitor: every accepted read must show up as one rd_valid cycle.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (rv_s) begin
                if (exp_std.size() == 0) begin
                    chk("std_spurious_rd_valid", 32'd1, 32'd0);
                end else begin
                    chk("std_dout", dout_s, exp_std.pop_front());
                end
            end else if (exp_std.size() != 0) begin
                chk("std_missing_rd_valid", 32'd0, 32'd1);
                void'(exp_std.pop_front());
            end
        end
    end

    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        chk({tag, "_count_s"}, 32'(count_s), 32'(n));
        chk({tag, "_count_f"}, 32'(count_f), 32'(n));
        chk({tag, "_flags_s"}, {28'd0, empty_s, full_s, ae_s, af_s},
            {28'd0, n == 0, n == DEPTH, n <= 2, n >= 14});
        chk({tag, "_flags_f"}, {28'd0, empty_f, full_f, ae_f, af_f},
            {28'd0, n == 0, n == DEPTH, n <= 2, n >= 14});
        chk({tag, "_err_s"}, {30'd0, ovf_s, unf_s}, {30'd0, m_ovf, m_unf});
        chk({tag, "_err_f"}, {30'd0, ovf_f, unf_f}, {30'd0, m_ovf, m_unf});
        chk({tag, "_fwft_dout"}, dout_f, (n == 0) ? '0 : model_q[0]);
        chk({tag, "_fwft_rv"}, 32'(rv_f), 32'(n != 0));
    endtask

    task automatic step(input logic w, input logic r, input logic fl,
                        input logic [DW-1:0] d);
        int n;
        wr_en = w; rd_en = r; flush = fl; din = d;
        @(posedge clk);
        n = model_q.size();
        if (fl) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && n == DEPTH) m_ovf = 1'b1;
            if (r && n == 0) m_unf = 1'b1;
            if (r && n > 0) exp_std.push_back(model_q.pop_front());
            if (w && n < DEPTH) model_q.push_back(d);
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        check_state("step");
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_count"}, 32'(count_s), 32'd0);
        chk({tag, "_std_out"}, {dout_s[30:0], rv_s}, 32'd0);
        chk({tag, "_flags"}, {24'd0, empty_s, full_s, ae_s, af_s,
                              empty_f, ovf_s, unf_s, rv_f},
            {24'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk({tag, "_dout_s"}, dout_s, '0);
        chk({tag, "_dout_f"}, dout_f, '0);
    endtask

    logic [DW-1:0] held;

    initial begin
        rst = 1'b1; flush = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        #12;
        reset_checks("reset");
        rst = 1'b0;

        // Fill to full, overflow, then drain in order.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 32'hA0 + 32'(i));
        chk("t1_full", 32'(full_s), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD);
        chk("t1_overflow", 32'(ovf_s), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, '0);
        chk("t1_last_dout", dout_s, 32'hAF);
        step(1'b0, 1'b0, 1'b1, '0);

        // Simultaneous read/write at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h200 + 32'(i));
        chk("t2_count", 32'(count_s), 32'd5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0);

        // FWFT fall-through of a single word.
        step(1'b1, 1'b0, 1'b0, 32'h1234);
        chk("t3_fwft_dout", dout_f, 32'h1234);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("t3_fwft_empty", {31'd0, empty_f}, 32'd1);

        // Underflow keeps STD dout; flush clears the flag.
        held = dout_s;
        step(1'b0, 1'b1, 1'b0, '0);
        chk("t4_underflow", 32'(unf_s), 32'd1);
        chk("t4_dout_hold", dout_s, held);
        step(1'b0, 1'b0, 1'b1, '0);
        chk("t4_flush_unf", 32'(unf_s), 32'd0);

        // Flush beats simultaneous read and write.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 32'h300 + 32'(i));
        step(1'b1, 1'b1, 1'b1, 32'hBAD);
        chk("t5_count", 32'(count_s), 32'd0);
        chk("t5_std_out", {dout_s[30:0], rv_s}, 32'd0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 32'h400 + 32'(i));
        step(1'b1, 1'b1, 1'b0, 32'h407);
        #2 rst = 1'b1;
        #1;
        reset_checks("t6_async");
        model_q.delete(); exp_std.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        #1 rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h55);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("t6_std_55", dout_s, 32'h55);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0),
                 $urandom);
        end

        step(1'b0, 1'b0, 1'b0, '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
